// File: rtl/commutation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : commutation_sequencer
// Description : Timed 6-step commutation controller for an 8-bit bridge-drive
//               bus. Steps through six phase patterns at a programmable rate
//               in either direction, with an all-off dead-time gap between
//               patterns and a latched fault shutdown.
// Revision    : 1.0 - initial release
// ============================================================================
module commutation_sequencer #(
    parameter int PER_W    = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic [PER_W-1:0] period,
    input  logic             fault,
    input  logic             fault_clr,
    output logic [7:0]       phase_out,
    output logic [2:0]       step,
    output logic             step_pulse,
    output logic             busy,
    output logic             fault_latched
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam logic [7:0]       c_DEAD_LAST = 8'(DEAD_CYC - 1);
    localparam logic [PER_W-1:0] c_PER_ONE   = {{(PER_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_phase;
    logic [7:0]       w_phase_nxt;
    logic [2:0]       r_step;
    logic [2:0]       w_step_nxt;
    logic [2:0]       w_step_adv;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] w_cnt_nxt;
    logic [PER_W-1:0] r_per_q;
    logic [PER_W-1:0] w_per_nxt;
    logic [7:0]       r_dcnt;
    logic [7:0]       w_dcnt_nxt;

    // Gate-drive pattern per step; out-of-range indices drive everything off.
    function automatic logic [7:0] pattern(input logic [2:0] idx);
        logic [7:0] pat;
        case (idx)
            3'd0:    pat = 8'b1001_0000;
            3'd1:    pat = 8'b0001_1000;
            3'd2:    pat = 8'b0100_1000;
            3'd3:    pat = 8'b0110_0000;
            3'd4:    pat = 8'b0010_0100;
            3'd5:    pat = 8'b1000_0100;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    // Next step index in the requested direction, wrapping modulo 6.
    always_comb begin
        w_step_adv = r_step;
        if (dir) begin
            w_step_adv = (r_step >= 3'd5) ? 3'd0 : r_step + 3'd1;
        end else begin
            w_step_adv = (r_step == 3'd0 || r_step > 3'd5) ? 3'd5 : r_step - 3'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode: fault beats enable-low beats sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per_q;
        w_dcnt_nxt  = r_dcnt;
        // fault wins over a simultaneous clear
        if (fault) begin
            w_fault_nxt = 1'b1;
        end else if (fault_clr) begin
            w_fault_nxt = 1'b0;
        end else begin
            w_fault_nxt = r_fault;
        end

        if (fault) begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = 8'h00;
            w_cnt_nxt   = '0;
            w_dcnt_nxt  = 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // the registered flag blocks restart until cleared
                    if (enable && !r_fault) begin
                        w_state_nxt = ST_DRIVE;
                        w_phase_nxt = pattern(r_step);
                        w_cnt_nxt   = '0;
                        w_per_nxt   = period;
                    end
                end
                ST_DRIVE: begin
                    if (!enable) begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 8'h00;
                        w_cnt_nxt   = '0;
                        w_dcnt_nxt  = 8'h00;
                    end else if (r_per_q == '0) begin
                        // zero period holds the step and keeps re-sampling
                        w_per_nxt = period;
                        w_cnt_nxt = '0;
                    end else if (r_cnt == r_per_q - c_PER_ONE) begin
                        w_state_nxt = ST_DEAD;
                        w_phase_nxt = 8'h00;
                        w_step_nxt  = w_step_adv;
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_dcnt_nxt  = 8'h00;
                    end else begin
                        w_cnt_nxt = r_cnt + c_PER_ONE;
                    end
                end
                ST_DEAD: begin
                    if (!enable) begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 8'h00;
                        w_cnt_nxt   = '0;
                        w_dcnt_nxt  = 8'h00;
                    end else if (r_dcnt == c_DEAD_LAST) begin
                        w_state_nxt = ST_DRIVE;
                        w_phase_nxt = pattern(r_step);
                        w_cnt_nxt   = '0;
                        w_per_nxt   = period;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 8'h00;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 8'h00;
            r_step  <= 3'd0;
            r_pulse <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_per_q <= '0;
            r_dcnt  <= 8'h00;
        end else begin
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
            r_pulse <= w_pulse_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
            r_per_q <= w_per_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    assign phase_out     = r_phase;
    assign step          = r_step;
    assign step_pulse    = r_pulse;
    assign busy          = (r_state != ST_IDLE);
    assign fault_latched = r_fault;

endmodule
`default_nettype wire
